// File: rtl/assay_dose_sequencer_pkg.sv
// assay_seq_pkg: shared types and helpers for the assay dose sequencer.
// Holds the FSM state enum, default phase lengths and channel search.
package assay_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DOSE,
    MIX,
    FLUSH,
    DONE
  } assay_state_e;

  localparam int DEF_MIX_CYCLES   = 64;
  localparam int DEF_FLUSH_CYCLES = 32;
  localparam int MAX_CH           = 16;
  localparam int CH_IDX_W         = 5;

  // Lowest set index in nz at or above from; MAX_CH when none remain.
  function automatic logic [CH_IDX_W-1:0] next_ch(
    input logic [MAX_CH-1:0]   nz,
    input logic [CH_IDX_W-1:0] from
  );
    logic [CH_IDX_W-1:0] r;
    r = CH_IDX_W'(MAX_CH);
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i >= int'(from) && nz[i]) r = CH_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/assay_dose_sequencer_if.sv
// assay_dose_sequencer_if: host-side dwell register write bus.
// master drives a write, slave (the sequencer) samples it.
interface assay_dose_sequencer_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_dwell;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_dwell
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_dwell
  );
endinterface

// File: rtl/assay_dose_sequencer_dwell_timer.sv
// dwell_timer: loadable down-counter shared by dose, mix and flush.
// Loaded with length-1; expire is high while the count sits at zero.
module dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire,
  output logic [CNT_W-1:0] cnt
);

  // Count down to zero and hold there; a load always takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/assay_dose_sequencer.sv
// assay_dose_sequencer: timed inlet dosing, mixing and optional flush.
// Define ASSAY_SEQ_FLUSH_EN to include the outlet flush phase.
module assay_dose_sequencer
  import assay_seq_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int CNT_W        = 16,
  parameter int MIX_CYCLES   = DEF_MIX_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  assay_dose_sequencer_if.slave cfg,
  output logic [NUM_CH-1:0]    valve_open,
  output logic                 mix_en,
  output logic                 flush_open,
  output logic                 busy,
  output logic                 done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] MIX_LD = CNT_W'(MIX_CYCLES - 1);

  assay_state_e        state, nstate;
  logic [CH_IDX_W-1:0] ch, nch, first, after;
  logic [CNT_W-1:0]    dwell [NUM_CH];
  logic [CNT_W-1:0]    first_dw, after_dw;
  logic [MAX_CH-1:0]   nz;
  logic                load, expire, tmr_en;
  logic [CNT_W-1:0]    load_val, unused_cnt;

  // Flag channels with a non-zero dwell and fetch candidate dwells.
  always_comb begin
    nz       = '0;
    first_dw = '0;
    after_dw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      nz[i] = (dwell[i] != '0);
      if (first == CH_IDX_W'(i)) first_dw = dwell[i];
      if (after == CH_IDX_W'(i)) after_dw = dwell[i];
    end
  end

  assign first  = next_ch(nz, '0);
  assign after  = next_ch(nz, ch + 1'b1);
  assign tmr_en = (state == DOSE) || (state == MIX) ||
                  (state == FLUSH);

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .en       (tmr_en),
    .expire   (expire),
    .cnt      (unused_cnt)
  );

  // Next-state logic; each phase transition reloads the shared timer.
  always_comb begin
    nstate   = state;
    nch      = ch;
    load     = 1'b0;
    load_val = '0;
    if (abort) begin
      nstate = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          load = 1'b1;
          if (int'(first) < NUM_CH) begin
            nstate   = DOSE;
            nch      = first;
            load_val = first_dw - 1'b1;
          end else begin
            nstate   = MIX;
            load_val = MIX_LD;
          end
        end
        DOSE: if (expire) begin
          load = 1'b1;
          if (int'(after) < NUM_CH) begin
            nch      = after;
            load_val = after_dw - 1'b1;
          end else begin
            nstate   = MIX;
            load_val = MIX_LD;
          end
        end
`ifdef ASSAY_SEQ_FLUSH_EN
        MIX: if (expire) begin
          nstate   = FLUSH;
          load     = 1'b1;
          load_val = CNT_W'(FLUSH_CYCLES - 1);
        end
`else
        MIX: if (expire) nstate = DONE;
`endif
        FLUSH: if (expire) nstate = DONE;
        DONE: nstate = IDLE;
        default: nstate = IDLE;
      endcase
    end
  end

  // State and active channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= nstate;
      ch    <= nch;
    end
  end

  // Dwell registers only change while no assay is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) dwell[i] <= '0;
    end else if (cfg.cfg_we && (state == IDLE || state == DONE)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg.cfg_ch == CH_W'(i)) dwell[i] <= cfg.cfg_dwell;
      end
    end
  end

  // Registered drives decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valve_open <= '0;
      mix_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        valve_open[i] <= (nstate == DOSE) && (nch == CH_IDX_W'(i));
      end
      mix_en <= (nstate == MIX);
      busy   <= (nstate == DOSE) || (nstate == MIX) ||
                (nstate == FLUSH);
      done   <= (nstate == DONE);
    end
  end

`ifdef ASSAY_SEQ_FLUSH_EN
  // Outlet flush valve drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_open <= 1'b0;
    else        flush_open <= (nstate == FLUSH);
  end
`else
  wire unused_flush = |32'(FLUSH_CYCLES);
  assign flush_open = 1'b0;
`endif

endmodule
